// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam int         FRAME_LEN    = 11;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       busy;

  modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_err, busy);
  modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_err, busy);
endinterface

// File: rtl/ps2_sync_edge.sv
// 2-FF synchronizer for one PS/2 pin plus a one-cycle falling-edge strobe.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);
  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], pin_i};
    prev_d = sync_q[1];
  end

  // Idle PS/2 lines are high; resetting to 1 avoids a false fall after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[1];
  assign fall_o  = prev_q & ~sync_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift, ack check.
// Define PS2_TX_TIMEOUT_EN to build the watchdog that aborts a stalled frame.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);
  localparam int INH = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int CW  = $clog2(INH + 1);

  if (INH < 2) begin : g_bad_inh
    $error("inhibit window must be at least 2 cycles");
  end
  if (TIMEOUT_MS < 1) begin : g_bad_to
    $error("TIMEOUT_MS must be positive");
  end

  ps2_tx_state_t  state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           clk_oe_q, clk_oe_d;
  logic           data_oe_q, data_oe_d;
  logic           done, err, timeout;
  logic           clk_lvl, clk_fall, data_lvl, data_fall_unused;

  ps2_sync_edge u_clk_sync  (.clk, .rst_n, .pin_i(ps2_clk_i),  .level_o(clk_lvl),  .fall_o(clk_fall));
  ps2_sync_edge u_data_sync (.clk, .rst_n, .pin_i(ps2_data_i), .level_o(data_lvl), .fall_o(data_fall_unused));

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int WW = $clog2(TO + 1);
  logic [WW-1:0] wd_q, wd_d;

  // Held at 0 until the clock is released, so it counts cycles since SHIFT entry.
  always_comb begin
    wd_d = '0;
    if (state_q inside {SHIFT, ACK, WAIT_IDLE}) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end

  assign timeout = (state_q inside {SHIFT, ACK, WAIT_IDLE}) && (wd_q == WW'(TO));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx.tx_valid) begin
          shift_d  = tx.tx_data;
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        // Start bit goes out one cycle before the clock is released.
        if (cnt_q == CW'(INH - 2)) data_oe_d = 1'b1;
        if (cnt_q == CW'(INH - 1)) begin
          clk_oe_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < 4'd8)       data_oe_d = ~shift_q[bit_cnt_q[2:0]];
          else if (bit_cnt_q == 4'd8) data_oe_d = ~odd_par(shift_q);
          else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (data_lvl) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done      = 1'b0;
      err       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx.tx_ready = (state_q == IDLE);
  assign tx.busy     = (state_q != IDLE);
  assign tx.tx_done  = done;
  assign tx.tx_err   = err;
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) to the keyboard over the same PS2Clk/PS2Data pair the `ps2` receiver listens on. It runs the full request-to-send sequence, shifts the frame on device-generated clocks, checks the device's line acknowledge and reports success or error. It sits beside `ps2` in `snake_top`, which maps the two open-drain enables onto the bidirectional pins (enable 1 drives the pin low, enable 0 releases it to Z).

## Interface
- CLK_HZ, 100_000_000: `clk` frequency.
- INHIBIT_US, 100: clock-inhibit duration, in µs.
- TIMEOUT_MS, 15: watchdog limit, in ms (see Configuration).
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset. Synchronous to `clk`, active low.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; the byte is accepted on `tx_valid & tx_ready`.
- tx_ready  out  1  high only in IDLE.
- tx_done  out  1  one-cycle pulse when the device acknowledges.
- tx_err  out  1  one-cycle pulse on NACK or timeout.
- busy  out  1  high in every state except IDLE. `snake_top` ignores receiver output while `busy` is high.
- ps2_clk_i  in  1  raw PS2Clk pin level (asynchronous).
- ps2_data_i  in  1  raw PS2Data pin level (asynchronous).
- ps2_clk_oe  out  1  1 pulls PS2Clk low.
- ps2_data_oe  out  1  1 pulls PS2Data low.

## Operation
- The pin inputs pass through a 2-FF synchronizer. `fall` is a one-cycle strobe generated on synchronized clock 1→0.
- Odd parity: par = ~^tx_data.
- The frame is: start 0, data bits 0..7 (LSB first), par, stop 1.
- **IDLE**: both enables are 0 and `tx_ready` is 1. On an accepted request, latch `tx_data` into the shift register, go to INHIBIT.
- **INHIBIT**: `ps2_clk_oe` = 1. Count INH = CLK_HZ/1_000_000*INHIBIT_US cycles (10000 by default).
  - On the last cycle, set `ps2_data_oe` = 1 (start bit).
  - Next cycle: `ps2_clk_oe` = 0, go to SHIFT with bit count 0.
- **SHIFT**: on each `fall`, increment the bit count and drive the next frame bit.
  - Falls 1–8: `ps2_data_oe` = ~data bit (bit count − 1).
  - Fall 9: `ps2_data_oe` = ~par.
  - Fall 10: `ps2_data_oe` = 0 (stop, line released). Go to ACK.
- **ACK**: on the next `fall`, sample the synchronized data.
  - 0: the device acknowledged. Go to WAIT_IDLE.
  - 1: NACK. Pulse `tx_err`, go to IDLE.
- **WAIT_IDLE**: wait until synchronized clock and data are both 1. Then pulse `tx_done` and go to IDLE.
- `tx_valid` while `busy` is ignored; the request is not queued.
- Glitch-free outputs: both enables are registered.

## Timing
- Reset values: `tx_ready` = 1. `tx_done`, `tx_err`, `busy`, `ps2_clk_oe`, `ps2_data_oe` = 0. State IDLE, counters 0.
- Reset mid-frame: both pins are released on the first `clk` edge with `rst_n` low. No `tx_err` is emitted.
- Acceptance → `ps2_clk_oe` high: 1 cycle.
- `ps2_clk_oe` stays high exactly INH cycles. `ps2_data_oe` rises on the last of those cycles, so it overlaps the inhibit by 1 cycle.
- Pin fall → `ps2_data_oe` update: 3 cycles (2 synchronizer + 1 register).
  - This is well inside the ≥30 µs clock-low half period, so data is stable before the device's rising-edge sample.
- `tx_done` / `tx_err` each assert for exactly one cycle. `tx_ready` returns high on the following cycle.
- A `fall` in IDLE or INHIBIT is ignored.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A watchdog counts from the clock release (entry to SHIFT) until `tx_done`/`tx_err`.
  - At CLK_HZ/1000*TIMEOUT_MS cycles (1,500,000 by default) it releases both pins, pulses `tx_err` and returns to IDLE.
  - If the watchdog expiry and a `fall` arrive in the same cycle, the timeout wins.
- `PS2_TX_TIMEOUT_EN` undefined:
  - No watchdog counter is built; `tx_err` indicates NACK only.
  - A silent device holds the FSM in SHIFT until reset.

## Structure
- Package `ps2_pkg`:
  - state enum: IDLE, INHIBIT, SHIFT, ACK, WAIT_IDLE;
  - command constants CMD_SET_LEDS 8'hED and CMD_RESET 8'hFF;
  - response constant RSP_ACK 8'hFA;
  - frame length 11.
- Sub-module `ps2_sync_edge`: 2-FF synchronizer plus falling-edge strobe, instantiated once per pin. The `ps2` receiver can reuse it.

## Test plan
- **Send 8'hED** with a device model that clocks at 12.5 kHz and acks:
  - `ps2_clk_oe` high for exactly 10000 cycles;
  - line bits sampled on device rising edges = 0, 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `tx_done` pulses once; `tx_err` stays 0.
- **Parity sweep**: bytes 8'h00, 8'h01, 8'hFF, 8'h80 → sampled parity 1, 0, 1, 0.
- **NACK**: the device leaves data high on the 11th fall → one `tx_err` pulse, no `tx_done`, both enables 0, `tx_ready` 1.
- **Timeout** (macro on): the device never clocks → `tx_err` exactly 1,500,000 cycles after the clock release.
- **Timeout** (macro off): the device never clocks → no `tx_err`, FSM held in SHIFT.
- **Reset at fall 5**: `rst_n` low for one cycle → both enables 0 and `tx_ready` 1 on the next cycle, no pulses.
- **Busy rejection**: `tx_valid` with 8'h55 asserted during SHIFT of 8'hED → ignored, frame carries 8'hED, exactly one `tx_done`.
